// File: rtl/uart_pkg.sv
// uart_pkg
// Definitions shared by the UART transmit and receive paths: the frame
// state encoding, parity mode constants, data width, oversampling ratio
// and a parity helper.
package uart_pkg;

  // Frame states. The receiver walks the same sequence.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int PARITY_NONE   = 0;
  localparam int PARITY_EVEN   = 1;
  localparam int PARITY_ODD    = 2;

  localparam int DATA_BITS     = 8;
  localparam int TICKS_PER_BIT = 16;

  // Parity bit for a byte: even mode returns the XOR of the data bits,
  // so the total count of ones including the parity bit is even.
  // Odd mode returns the inverse.
  function automatic logic parityBit(input logic [DATA_BITS-1:0] data,
                                     input int                   mode);
    parityBit = (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_tx_tick.sv
// uart_tx_tick
// 16x baud tick divider for the transmitter. It counts 0..CNTMAX while
// enabled and raises o_tick in the cycle the count reaches CNTMAX.
// It is kept apart from the free-running receive divider because the
// transmitter must restart it from zero when it accepts a byte.
//
// Ports:
//   i_clkin   system clock, rising edge
//   i_rst     synchronous active-high reset
//   i_clear   synchronous clear of the count (takes effect regardless of enable)
//   i_enable  count enable
//   o_tick    one-cycle pulse every CNTMAX+1 enabled clocks
module uart_tx_tick
  import uart_pkg::*;
#(
  parameter int CLKS     = 100000000,
  parameter int BAUDRATE = 9600
) (
  input  logic i_clkin,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  // Same divider arithmetic as the receive side. A rate too high for the
  // clock would give a negative terminal count, so it is clamped to a
  // tick on every enabled clock.
  localparam int CNTMAX_RAW = CLKS / BAUDRATE / TICKS_PER_BIT - 1;
  localparam int CNTMAX     = (CNTMAX_RAW < 0) ? 0 : CNTMAX_RAW;
  localparam int CNT_W      = (CNTMAX > 0) ? $clog2(CNTMAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNTMAX);

  logic [CNT_W-1:0] r_cnt;

  // Divider count: held at zero by reset or clear, otherwise counts up
  // while enabled and wraps after the terminal value.
  always_ff @(posedge i_clkin) begin
    if (i_rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_tick = i_enable && (r_cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx
// UART transmitter. Takes one byte per valid/ready handshake and shifts
// it out on o_txd as a start bit, 8 data bits LSB first, an optional
// parity bit and 1 or 2 stop bits. Each bit lasts 16 divider ticks.
//
// Ports:
//   i_clkin     system clock, rising edge
//   i_rst       synchronous active-high reset
//   i_tx_data   byte to send, sampled only on accept
//   i_tx_valid  source has a byte
//   o_tx_ready  block can accept (high only in IDLE)
//   o_txd       registered serial line, idles high
//   o_tx_busy   frame in progress
//   o_tx_done   one-clock pulse in the first IDLE cycle after a frame
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS        = 100000000,
  parameter int BAUDRATE    = 9600,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic       i_clkin,
  input  logic       i_rst,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_txd,
  output logic       o_tx_busy,
  output logic       o_tx_done
);

  // Unsupported settings fall back to no parity and one stop bit.
  localparam int PMODE = ((PARITY_MODE == PARITY_EVEN) || (PARITY_MODE == PARITY_ODD))
                         ? PARITY_MODE : PARITY_NONE;
  localparam int NSTOP = (STOP_BITS == 2) ? 2 : 1;

  localparam logic [3:0] LAST_TICK = 4'(TICKS_PER_BIT - 1);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(NSTOP - 1);

  uart_state_e r_state, w_stateNext;
  logic [7:0]  r_shift, w_shiftNext;
  logic        r_parity, w_parityNext;
  logic [2:0]  r_bitIdx, w_bitIdxNext;
  logic [3:0]  r_tickCnt, w_tickCntNext;
  logic        r_stopCnt, w_stopCntNext;
  logic        r_txd, w_txdNext;
  logic        r_done, w_doneNext;

  logic        w_accept;
  logic        w_tick;
  logic        w_bitEnd;

  assign w_accept = (r_state == IDLE) && i_tx_valid;

  // The divider only runs during a frame and restarts on accept so the
  // start bit is a full 16 ticks long.
  uart_tx_tick #(
    .CLKS     (CLKS),
    .BAUDRATE (BAUDRATE)
  ) u_tick (
    .i_clkin  (i_clkin),
    .i_rst    (i_rst),
    .i_clear  (w_accept),
    .i_enable (r_state != IDLE),
    .o_tick   (w_tick)
  );

  // A bit ends on the 16th tick spent in it.
  assign w_bitEnd = w_tick && (r_tickCnt == LAST_TICK);

  // Next-state logic. The line level is computed from the state being
  // entered so that o_txd can be a plain register and still change in
  // the same cycle as the state.
  always_comb begin
    w_stateNext   = r_state;
    w_shiftNext   = r_shift;
    w_parityNext  = r_parity;
    w_bitIdxNext  = r_bitIdx;
    w_tickCntNext = w_tick ? (r_tickCnt + 4'd1) : r_tickCnt;
    w_stopCntNext = r_stopCnt;
    w_doneNext    = 1'b0;
    w_txdNext     = 1'b1;

    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_stateNext   = START;
          w_shiftNext   = i_tx_data;
          w_parityNext  = parityBit(i_tx_data, PMODE);
          w_bitIdxNext  = 3'd0;
          w_tickCntNext = 4'd0;
          w_stopCntNext = 1'b0;
        end
      end
      START: begin
        if (w_bitEnd) begin
          w_stateNext = DATA;
        end
      end
      DATA: begin
        if (w_bitEnd) begin
          w_shiftNext = r_shift >> 1;
          if (r_bitIdx == LAST_DATA) begin
            w_stateNext = (PMODE != PARITY_NONE) ? PARITY : STOP;
          end else begin
            w_bitIdxNext = r_bitIdx + 3'd1;
          end
        end
      end
      PARITY: begin
        if (w_bitEnd) begin
          w_stateNext = STOP;
        end
      end
      STOP: begin
        if (w_bitEnd) begin
          if (r_stopCnt == LAST_STOP) begin
            w_stateNext = IDLE;
            w_doneNext  = 1'b1;
          end else begin
            w_stopCntNext = r_stopCnt + 1'b1;
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase

    unique case (w_stateNext)
      START:   w_txdNext = 1'b0;
      DATA:    w_txdNext = w_shiftNext[0];
      PARITY:  w_txdNext = w_parityNext;
      default: w_txdNext = 1'b1;
    endcase
  end

  // State register. Reset abandons any frame in progress and returns the
  // line to idle-high on the following cycle.
  always_ff @(posedge i_clkin) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_bitIdx  <= '0;
      r_tickCnt <= '0;
      r_stopCnt <= 1'b0;
      r_txd     <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_shift   <= w_shiftNext;
      r_parity  <= w_parityNext;
      r_bitIdx  <= w_bitIdxNext;
      r_tickCnt <= w_tickCntNext;
      r_stopCnt <= w_stopCntNext;
      r_txd     <= w_txdNext;
      r_done    <= w_doneNext;
    end
  end

  assign o_txd      = r_txd;
  assign o_tx_done  = r_done;
  assign o_tx_ready = (r_state == IDLE);
  assign o_tx_busy  = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx
// Bench for uart_tx. Four transmitters with different settings share one
// clock and reset: 8N1, 8E1, 8O1 (32-clock bits) and 8N2 (48-clock bits).
// Expected line levels come from a frame model built from the UART
// framing rules: start 0, data LSB first, parity from the count of ones,
// then stop bits of 1.
module tb_uart_tx;

  localparam int CLKS_A = 3200;
  localparam int CLKS_B = 4800;
  localparam int BAUD   = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] txData;
  logic [3:0] txValid;

  logic txd0, ready0, busy0, done0;
  logic txd1, ready1, busy1, done1;
  logic txd2, ready2, busy2, done2;
  logic txd3, ready3, busy3, done3;

  int nVectors    = 0;
  int nMiscompares = 0;

  typedef struct packed {
    logic txd;
    logic ready;
    logic busy;
    logic done;
  } obs_t;

  typedef struct {
    int          dut;
    logic [7:0]  data;
    int          expLen;
    int          nBits;
    logic [15:0] expBits;
  } vec_t;

  uart_tx #(.CLKS(CLKS_A), .BAUDRATE(BAUD), .PARITY_MODE(0), .STOP_BITS(1)) dut0 (
    .i_clkin(clk), .i_rst(rst), .i_tx_data(txData), .i_tx_valid(txValid[0]),
    .o_tx_ready(ready0), .o_txd(txd0), .o_tx_busy(busy0), .o_tx_done(done0));

  uart_tx #(.CLKS(CLKS_A), .BAUDRATE(BAUD), .PARITY_MODE(1), .STOP_BITS(1)) dut1 (
    .i_clkin(clk), .i_rst(rst), .i_tx_data(txData), .i_tx_valid(txValid[1]),
    .o_tx_ready(ready1), .o_txd(txd1), .o_tx_busy(busy1), .o_tx_done(done1));

  uart_tx #(.CLKS(CLKS_A), .BAUDRATE(BAUD), .PARITY_MODE(2), .STOP_BITS(1)) dut2 (
    .i_clkin(clk), .i_rst(rst), .i_tx_data(txData), .i_tx_valid(txValid[2]),
    .o_tx_ready(ready2), .o_txd(txd2), .o_tx_busy(busy2), .o_tx_done(done2));

  uart_tx #(.CLKS(CLKS_B), .BAUDRATE(BAUD), .PARITY_MODE(0), .STOP_BITS(2)) dut3 (
    .i_clkin(clk), .i_rst(rst), .i_tx_data(txData), .i_tx_valid(txValid[3]),
    .o_tx_ready(ready3), .o_txd(txd3), .o_tx_busy(busy3), .o_tx_done(done3));

  always #5 clk = ~clk;

  // Clocks per bit: 16 ticks of CLKS/BAUD/16 clocks each.
  function automatic int bitLen(input int d);
    return ((d == 3 ? CLKS_B : CLKS_A) / BAUD / 16) * 16;
  endfunction

  function automatic int parityMode(input int d);
    return (d == 1) ? 1 : ((d == 2) ? 2 : 0);
  endfunction

  function automatic int stopCount(input int d);
    return (d == 3) ? 2 : 1;
  endfunction

  // Reference frame: the sequence of line levels, one entry per bit.
  function automatic void modelFrame(input int d, input logic [7:0] data,
                                     output logic [15:0] bits, output int n);
    int ones;
    bits = '0;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin
      bits[n] = data[i]; n++;
    end
    ones = $countones(data);
    if (parityMode(d) == 1) begin
      bits[n] = (ones % 2 == 1); n++;
    end else if (parityMode(d) == 2) begin
      bits[n] = (ones % 2 == 0); n++;
    end
    for (int s = 0; s < stopCount(d); s++) begin
      bits[n] = 1'b1; n++;
    end
  endfunction

  function automatic obs_t sampleDut(input int d);
    obs_t o;
    case (d)
      0:       o = '{txd0, ready0, busy0, done0};
      1:       o = '{txd1, ready1, busy1, done1};
      2:       o = '{txd2, ready2, busy2, done2};
      default: o = '{txd3, ready3, busy3, done3};
    endcase
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  // Sends one byte to DUT d and checks every clock of the frame against
  // the model. Entered and left at #1 after a rising edge. tx_data is
  // disturbed mid-frame; with keepValid the valid line stays high and the
  // bench returns in the tx_done cycle so the next call can chain a frame.
  task automatic applyStimulus(input int d, input logic [7:0] data,
                               input logic [7:0] nextData, input bit keepValid,
                               output logic [15:0] seen, output int doneIdx);
    logic [15:0] expBits;
    int          nBits;
    int          bl;
    int          idx;
    int          busyErr;
    logic        badVal;
    obs_t        o;
    modelFrame(d, data, expBits, nBits);
    bl      = bitLen(d);
    seen    = '0;
    doneIdx = -1;
    busyErr = 0;
    idx     = 0;
    txData     = data;
    txValid[d] = 1'b1;
    @(posedge clk); #1;
    if (!keepValid) txValid[d] = 1'b0;
    for (int b = 0; b < nBits; b++) begin
      badVal = expBits[b];
      for (int c = 0; c < bl; c++) begin
        if (b == 1 && c == 3) txData = keepValid ? nextData : 8'($urandom);
        o = sampleDut(d);
        if (o.txd !== expBits[b]) badVal = o.txd;
        if (c == bl / 2) seen[b] = o.txd;
        if (o.busy !== 1'b1 || o.ready !== 1'b0) busyErr++;
        if (o.done === 1'b1 && doneIdx < 0) doneIdx = idx;
        idx++;
        @(posedge clk); #1;
      end
      checkOutput($sformatf("dut%0d byte %02h txd bit %0d", d, data, b), badVal, expBits[b]);
    end
    o = sampleDut(d);
    if (o.done === 1'b1 && doneIdx < 0) doneIdx = idx;
    checkOutput($sformatf("dut%0d cycles to done", d), doneIdx, idx);
    checkOutput($sformatf("dut%0d busy/ready errors in frame", d), busyErr, 0);
    checkOutput($sformatf("dut%0d ready after frame", d), o.ready, 1);
    checkOutput($sformatf("dut%0d busy after frame", d), o.busy, 0);
    checkOutput($sformatf("dut%0d txd after frame", d), o.txd, 1);
    if (!keepValid) begin
      @(posedge clk); #1;
      o = sampleDut(d);
      checkOutput($sformatf("dut%0d done pulse width", d), o.done, 0);
      checkOutput($sformatf("dut%0d ready stays high", d), o.ready, 1);
    end
  endtask

  vec_t        vecs[4];
  logic [15:0] seen;
  int          doneIdx;
  int          errCnt;
  obs_t        o;
  logic [15:0] mask;

  initial begin
    rst     = 1'b1;
    txValid = '0;
    txData  = 8'h00;

    // Reset held for three clocks with no valid.
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 4; d++) begin
        o = sampleDut(d);
        checkOutput($sformatf("reset dut%0d txd", d), o.txd, 1);
        checkOutput($sformatf("reset dut%0d ready", d), o.ready, 1);
        checkOutput($sformatf("reset dut%0d busy", d), o.busy, 0);
        checkOutput($sformatf("reset dut%0d done", d), o.done, 0);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed frames with hand-worked line levels and frame lengths.
    vecs[0] = '{0, 8'hA5, 320, 10, 16'b00000_0_1_10100101_0};
    vecs[1] = '{1, 8'h07, 352, 11, 16'b0000_1_1_00000111_0};
    vecs[2] = '{2, 8'h07, 352, 11, 16'b0000_1_0_00000111_0};
    vecs[3] = '{3, 8'h00, 528, 11, 16'b0000_1_1_00000000_0};
    for (int v = 0; v < 4; v++) begin
      applyStimulus(vecs[v].dut, vecs[v].data, 8'h00, 1'b0, seen, doneIdx);
      mask = 16'((32'd1 << vecs[v].nBits) - 1);
      checkOutput($sformatf("vec%0d line levels", v), seen & mask, vecs[v].expBits);
      checkOutput($sformatf("vec%0d frame length", v), doneIdx, vecs[v].expLen);
    end

    // Back-to-back: valid held high across two frames.
    applyStimulus(0, 8'h55, 8'hFF, 1'b1, seen, doneIdx);
    checkOutput("b2b first frame levels", seen[9:0], 10'b1_01010101_0);
    applyStimulus(0, 8'hFF, 8'h00, 1'b0, seen, doneIdx);
    checkOutput("b2b second frame levels", seen[9:0], 10'b1_11111111_0);
    errCnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      o = sampleDut(0);
      if (o.ready !== 1'b1 || o.txd !== 1'b1) errCnt++;
    end
    checkOutput("b2b no third accept", errCnt, 0);

    // Reset during data bit 3 of 0xF0 (line low there).
    txData     = 8'hF0;
    txValid[0] = 1'b1;
    @(posedge clk); #1;
    txValid[0] = 1'b0;
    for (int c = 0; c < 4 * 32 + 10; c++) begin
      @(posedge clk); #1;
    end
    o = sampleDut(0);
    checkOutput("abort txd before reset", o.txd, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    o = sampleDut(0);
    checkOutput("abort txd", o.txd, 1);
    checkOutput("abort ready", o.ready, 1);
    checkOutput("abort busy", o.busy, 0);
    checkOutput("abort done", o.done, 0);
    errCnt = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      o = sampleDut(0);
      if (o.done !== 1'b0 || o.txd !== 1'b1) errCnt++;
    end
    checkOutput("abort no done or activity", errCnt, 0);
    applyStimulus(0, 8'h3C, 8'h00, 1'b0, seen, doneIdx);
    checkOutput("after abort frame levels", seen[9:0], 10'b1_00111100_0);

    // Random bytes on every configuration.
    for (int d = 0; d < 4; d++) begin
      for (int n = 0; n < 5; n++) begin
        applyStimulus(d, 8'($urandom), 8'h00, 1'b0, seen, doneIdx);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
